// File: rtl/alu_defs_pkg.sv
// ---------------------------------------------------------------------------
// alu_defs
// Shared definitions for the ALU command issuer slice.
//   OP_ADD/OP_SUB/OP_AND/OP_OR : 2-bit ALU opcode encodings
//   state_t (S_IDLE/S_WAIT/S_RESP) : issuer FSM states
//   CMD_W   : width of one queued command entry
//   cmd_t   : packed layout of a queued command {opcode, a, b, chain}
//   selectOperandA : picks operand a, or the last result when chained
// ---------------------------------------------------------------------------
package alu_defs;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int CMD_W = 9;

  typedef struct packed {
    logic [1:0] opcode;
    logic [2:0] a;
    logic [2:0] b;
    logic       chain;
  } cmd_t;

  // A chained command ignores its own operand a and reuses the low three
  // bits of the most recently captured result instead.
  function automatic logic [2:0] selectOperandA(input cmd_t cmd,
                                                input logic [2:0] lastRes);
    return cmd.chain ? lastRes : cmd.a;
  endfunction

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// The team's 3-bit combinational ALU. Results are 4 bits, modulo 16.
//   a, b    : 3-bit operands
//   opcode  : OP_ADD / OP_SUB / OP_AND / OP_OR
//   z       : 4-bit result
// ---------------------------------------------------------------------------
module alu
  import alu_defs::*;
(
  input  logic [2:0] a,
  input  logic [2:0] b,
  input  logic [1:0] opcode,
  output logic [3:0] z
);

  // Operands are zero-extended to four bits so subtraction wraps modulo 16
  // (for example 2 - 5 gives 4'hD) and the logic ops leave bit 3 clear.
  always_comb begin
    z = 4'd0;
    case (opcode)
      OP_ADD:  z = {1'b0, a} + {1'b0, b};
      OP_SUB:  z = {1'b0, a} - {1'b0, b};
      OP_AND:  z = {1'b0, a & b};
      OP_OR:   z = {1'b0, a | b};
      default: z = 4'd0;
    endcase
  end

endmodule

// File: rtl/alu_cmd_issuer_fifo.sv
// ---------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous first-word fall-through FIFO holding queued ALU commands.
//   clk, rst : clock and synchronous active-high reset
//   push/din : write din when push and not full
//   pop      : drop the head entry when pop and not empty
//   dout     : current head entry (valid whenever empty is low)
//   full, empty, count : occupancy status
// ---------------------------------------------------------------------------
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int CMD_W = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [CMD_W-1:0]         din,
  output logic [CMD_W-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CMD_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  // Requests are qualified here so an overflowing push or an underflowing
  // pop can never corrupt the pointers or the occupancy count.
  assign w_doPush = push && !full;
  assign w_doPop  = pop && !empty;

  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rdPtr];

  // Storage array carries no reset; stale entries are unreachable because
  // the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two. A simultaneous
  // push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_doPush && !w_doPop) begin
        r_count <= r_count + 1'b1;
      end else if (w_doPop && !w_doPush) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// alu_cmd_issuer
// Sequential front end for the 3-bit combinational ALU. Commands arrive over
// a valid/ready handshake into a small FIFO, are driven to the ALU from
// registers, and the 4-bit result is returned over a second handshake.
//   clk, rst                  : clock and synchronous active-high reset
//   cmd_valid/cmd_ready       : command handshake
//   cmd_opcode/cmd_a/cmd_b    : command fields
//   cmd_chain                 : reuse last result[2:0] as operand a
//   alu_a/alu_b/alu_opcode    : registered ALU inputs
//   alu_z                     : combinational ALU result
//   res_valid/res_ready       : result handshake
//   res_data/res_zero         : captured result and its zero flag
//   res_count                 : completed-result counter, wraps at 256
// ---------------------------------------------------------------------------
module alu_cmd_issuer
  import alu_defs::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_opcode,
  input  logic [2:0] cmd_a,
  input  logic [2:0] cmd_b,
  input  logic       cmd_chain,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  output logic [1:0] alu_opcode,
  input  logic [3:0] alu_z,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic       res_zero,
  output logic [7:0] res_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  state_t           r_state;
  logic [2:0]       r_aluA;
  logic [2:0]       r_aluB;
  logic [1:0]       r_aluOp;
  logic             r_resValid;
  logic [3:0]       r_resData;
  logic             r_resZero;
  logic [7:0]       r_resCount;
  logic [2:0]       r_lastRes;

  cmd_t             w_inCmd;
  cmd_t             w_head;
  logic [CMD_W-1:0] w_headBits;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [2:0]       w_loadA;

  // cmd_ready looks only at the current count, so a pop in the same cycle
  // never opens the door for a push into a full FIFO.
  assign cmd_ready = (w_count < DEPTH_CNT);
  assign w_push    = cmd_valid && cmd_ready;

  assign w_inCmd = '{opcode: cmd_opcode, a: cmd_a, b: cmd_b, chain: cmd_chain};
  assign w_head  = cmd_t'(w_headBits);
  assign w_loadA = selectOperandA(w_head, r_lastRes);

  // The head is consumed exactly when the FSM loads it: from IDLE, or on a
  // result handshake in RESP for back-to-back issue.
  assign w_pop = !w_empty &&
                 ((r_state == S_IDLE) || ((r_state == S_RESP) && res_ready));

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .CMD_W (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_inCmd),
    .dout  (w_headBits),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Issue FSM. IDLE loads the head into the ALU registers, WAIT gives the
  // combinational ALU a full cycle to settle before capture, and RESP holds
  // the result until the consumer takes it. The ALU registers only change
  // on a load, and last_res only changes on a capture, so a chained command
  // always sees the result that was most recently produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_aluA     <= '0;
      r_aluB     <= '0;
      r_aluOp    <= '0;
      r_resValid <= 1'b0;
      r_resData  <= '0;
      r_resZero  <= 1'b1;
      r_resCount <= '0;
      r_lastRes  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_aluA  <= w_loadA;
            r_aluB  <= w_head.b;
            r_aluOp <= w_head.opcode;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_resData  <= alu_z;
          r_resZero  <= (alu_z == 4'd0);
          r_lastRes  <= alu_z[2:0];
          r_resValid <= 1'b1;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          if (res_ready) begin
            r_resValid <= 1'b0;
            r_resCount <= r_resCount + 8'd1;
            if (!w_empty) begin
              r_aluA  <= w_loadA;
              r_aluB  <= w_head.b;
              r_aluOp <= w_head.opcode;
              r_state <= S_WAIT;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign alu_a      = r_aluA;
  assign alu_b      = r_aluB;
  assign alu_opcode = r_aluOp;
  assign res_valid  = r_resValid;
  assign res_data   = r_resData;
  assign res_zero   = r_resZero;
  assign res_count  = r_resCount;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_issuer
// Directed self-checking bench for alu_cmd_issuer driving the real alu.
// ---------------------------------------------------------------------------
module tb_alu_cmd_issuer;
  import alu_defs::*;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_opcode;
  logic [2:0] cmd_a;
  logic [2:0] cmd_b;
  logic       cmd_chain;
  logic [2:0] alu_a;
  logic [2:0] alu_b;
  logic [1:0] alu_opcode;
  logic [3:0] alu_z;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic       res_zero;
  logic [7:0] res_count;

  int         checks;
  int         errors;
  logic [7:0] expCount;

  alu_cmd_issuer #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_chain  (cmd_chain),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_z      (alu_z),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_zero   (res_zero),
    .res_count  (res_count)
  );

  alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .opcode (alu_opcode),
    .z      (alu_z)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock; inputs are driven and outputs sampled at the negedge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // One comparison: counts it and reports tag/observed/expected on failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one command for a single edge; the caller ensures cmd_ready.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] a,
                               input logic [2:0] b, input logic chain);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_chain  = chain;
    tick();
    cmd_valid  = 1'b0;
  endtask

  // Full single-command transaction from an idle, empty issuer with
  // res_ready low: checks E1 operands, E2 result, and the handshake.
  task automatic runOne(input string tag, input logic [1:0] op,
                        input logic [2:0] a, input logic [2:0] b,
                        input logic chain, input logic [2:0] expA,
                        input logic [3:0] expZ);
    applyStimulus(op, a, b, chain);
    tick();
    checkOutput({tag, "_alu_a"}, alu_a, expA);
    checkOutput({tag, "_alu_b"}, alu_b, b);
    checkOutput({tag, "_alu_op"}, alu_opcode, op);
    checkOutput({tag, "_valid_e1"}, res_valid, 1'b0);
    tick();
    checkOutput({tag, "_valid_e2"}, res_valid, 1'b1);
    checkOutput({tag, "_data"}, res_data, expZ);
    checkOutput({tag, "_zero"}, res_zero, (expZ == 4'd0));
    tick();
    checkOutput({tag, "_hold"}, res_data, expZ);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    expCount  = expCount + 8'd1;
    checkOutput({tag, "_valid_done"}, res_valid, 1'b0);
    checkOutput({tag, "_count"}, res_count, expCount);
  endtask

  logic [3:0] bpExp [5];
  int         idx;
  int         lastCyc;
  int         seen;
  int         pushed;

  initial begin
    checks     = 0;
    errors     = 0;
    expCount   = 8'd0;
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_opcode = 2'b00;
    cmd_a      = 3'd0;
    cmd_b      = 3'd0;
    cmd_chain  = 1'b0;
    res_ready  = 1'b0;

    // Reset values.
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_cmd_ready", cmd_ready, 1'b1);
    checkOutput("rst_alu_a", alu_a, 3'd0);
    checkOutput("rst_alu_b", alu_b, 3'd0);
    checkOutput("rst_alu_op", alu_opcode, 2'd0);
    checkOutput("rst_res_valid", res_valid, 1'b0);
    checkOutput("rst_res_data", res_data, 4'd0);
    checkOutput("rst_res_zero", res_zero, 1'b1);
    checkOutput("rst_res_count", res_count, 8'd0);

    // Basic operations, SUB wrap, zero flag, AND, and a chain.
    runOne("add_3_4", OP_ADD, 3'd3, 3'd4, 1'b0, 3'd3, 4'h7);
    runOne("sub_2_5", OP_SUB, 3'd2, 3'd5, 1'b0, 3'd2, 4'hD);
    runOne("sub_5_5", OP_SUB, 3'd5, 3'd5, 1'b0, 3'd5, 4'h0);
    runOne("and_6_3", OP_AND, 3'd6, 3'd3, 1'b0, 3'd6, 4'h2);
    runOne("add_7_7", OP_ADD, 3'd7, 3'd7, 1'b0, 3'd7, 4'hE);
    runOne("chain_or", OP_OR, 3'd5, 3'd1, 1'b1, 3'd6, 4'h7);

    // Backpressure: five commands with res_ready low. The first is popped
    // straight into the ALU, so the FIFO fills on the fifth push.
    applyStimulus(OP_ADD, 3'd1, 3'd1, 1'b0);
    applyStimulus(OP_ADD, 3'd2, 3'd2, 1'b0);
    applyStimulus(OP_SUB, 3'd1, 3'd3, 1'b0);
    applyStimulus(OP_OR,  3'd4, 3'd2, 1'b0);
    checkOutput("bp_ready_before_full", cmd_ready, 1'b1);
    applyStimulus(OP_AND, 3'd7, 3'd5, 1'b0);
    checkOutput("bp_ready_full", cmd_ready, 1'b0);
    cmd_valid  = 1'b1;
    cmd_opcode = OP_ADD;
    cmd_a      = 3'd3;
    cmd_b      = 3'd3;
    cmd_chain  = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("bp_ready_stays_low", cmd_ready, 1'b0);
    checkOutput("bp_first_valid", res_valid, 1'b1);
    checkOutput("bp_first_data", res_data, 4'h2);
    res_ready = 1'b1;
    tick();
    expCount = expCount + 8'd1;
    checkOutput("bp_ready_after_pop", cmd_ready, 1'b1);
    checkOutput("bp_valid_after_hs", res_valid, 1'b0);
    tick();
    cmd_valid = 1'b0;
    bpExp[0] = 4'h4;
    bpExp[1] = 4'hE;
    bpExp[2] = 4'h6;
    bpExp[3] = 4'h5;
    bpExp[4] = 4'h6;
    idx      = 0;
    lastCyc  = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (res_valid) begin
        if (idx < 5) begin
          checkOutput($sformatf("bp_data_%0d", idx), res_data, bpExp[idx]);
        end else begin
          checkOutput("bp_extra_result", idx, 5);
        end
        if (idx > 0) begin
          checkOutput($sformatf("bp_spacing_%0d", idx), cyc - lastCyc, 2);
        end
        lastCyc  = cyc;
        idx++;
        expCount = expCount + 8'd1;
      end
      tick();
    end
    res_ready = 1'b0;
    checkOutput("bp_result_total", idx, 5);
    checkOutput("bp_count", res_count, expCount);

    // Reset while holding a result with three commands queued.
    applyStimulus(OP_ADD, 3'd1, 3'd2, 1'b0);
    applyStimulus(OP_ADD, 3'd2, 3'd3, 1'b0);
    applyStimulus(OP_ADD, 3'd3, 3'd4, 1'b0);
    applyStimulus(OP_ADD, 3'd4, 3'd1, 1'b0);
    checkOutput("mid_valid_before_rst", res_valid, 1'b1);
    checkOutput("mid_data_before_rst", res_data, 4'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expCount = 8'd0;
    checkOutput("mid_rst_cmd_ready", cmd_ready, 1'b1);
    checkOutput("mid_rst_alu_a", alu_a, 3'd0);
    checkOutput("mid_rst_alu_b", alu_b, 3'd0);
    checkOutput("mid_rst_res_valid", res_valid, 1'b0);
    checkOutput("mid_rst_res_data", res_data, 4'd0);
    checkOutput("mid_rst_res_zero", res_zero, 1'b1);
    checkOutput("mid_rst_res_count", res_count, 8'd0);
    res_ready = 1'b1;
    seen      = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (res_valid) seen++;
      tick();
    end
    res_ready = 1'b0;
    checkOutput("mid_no_stale_results", seen, 0);
    checkOutput("mid_alu_a_untouched", alu_a, 3'd0);

    // last_res was cleared by reset, so a chain now sees operand a = 0.
    runOne("chain_after_rst", OP_ADD, 3'd6, 3'd2, 1'b1, 3'd0, 4'h2);

    // Counter wrap: 255 more handshakes take res_count from 1 back to 0.
    res_ready = 1'b1;
    pushed    = 0;
    seen      = 0;
    for (int cyc = 0; cyc < 3000 && seen < 255; cyc++) begin
      cmd_valid  = (pushed < 255);
      cmd_opcode = OP_ADD;
      cmd_a      = 3'd1;
      cmd_b      = 3'd1;
      cmd_chain  = 1'b0;
      if (cmd_valid && cmd_ready) pushed++;
      if (res_valid) begin
        seen++;
        expCount = expCount + 8'd1;
      end
      tick();
    end
    cmd_valid = 1'b0;
    tick();
    tick();
    res_ready = 1'b0;
    checkOutput("wrap_handshakes", seen, 255);
    checkOutput("wrap_count", res_count, expCount);
    checkOutput("wrap_count_zero", res_count, 8'd0);
    checkOutput("wrap_idle_valid", res_valid, 1'b0);
    checkOutput("wrap_last_data", res_data, 4'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
